// File: rtl/thermo_pkg.sv
// Shared thermostat definitions: actuator FSM state encoding and default dwell times.
package thermo_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HEAT = 2'd1,
      COOL = 2'd2,
      REST = 2'd3
   } thermo_state_t;

   localparam int MIN_ON_DEF  = 16;
   localparam int MIN_OFF_DEF = 16;
   localparam int CNT_W_DEF   = 8;

endpackage

// File: rtl/dwell_timer.sv
// Saturating dwell counter with synchronous clear; measures cycles spent in a state.
module dwell_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (cnt != '1)
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/thermo_actuator.sv
// Heater/cooler enable controller with minimum run time, post-run rest and
// contradictory-demand flag.
module thermo_actuator
   import thermo_pkg::*;
#(
   parameter int MIN_ON  = MIN_ON_DEF,
   parameter int MIN_OFF = MIN_OFF_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       Hon,
   input  logic       Con,
   output logic       heat_out,
   output logic       cool_out,
   output logic       fault,
   output logic [1:0] state
);

   localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(MIN_ON - 1);
   localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(MIN_OFF - 1);

   thermo_state_t    state_q, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             h, c;

   // Simultaneous demands cancel out; only the fault flag reports them.
   assign h = Hon & ~Con;
   assign c = Con & ~Hon;

   dwell_timer #(.CNT_W(CNT_W)) u_dwell (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state_nxt != state_q),
      .cnt   (cnt)
   );

   always_comb begin
      state_nxt = state_q;
      unique case (state_q)
         IDLE: begin
            if (en && h)
               state_nxt = HEAT;
            else if (en && c)
               state_nxt = COOL;
         end
         HEAT: begin
            if (!en || (cnt >= ON_LAST && !h))
               state_nxt = REST;
         end
         COOL: begin
            if (!en || (cnt >= ON_LAST && !c))
               state_nxt = REST;
         end
         REST: begin
            if (cnt == OFF_LAST)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Enables are flopped alongside the state so they track it exactly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         heat_out <= 1'b0;
         cool_out <= 1'b0;
         fault    <= 1'b0;
      end else begin
         state_q  <= state_nxt;
         heat_out <= (state_nxt == HEAT);
         cool_out <= (state_nxt == COOL);
         fault    <= Hon & Con;
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_thermo_actuator.sv
// Scoreboard bench for thermo_actuator with MIN_ON=4, MIN_OFF=3.
module tb_thermo_actuator;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en, Hon, Con;
   logic       heat_out, cool_out, fault;
   logic [1:0] state;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0] st;
      logic       ho;
      logic       co;
      logic       f;
      string      name;
   } exp_t;

   exp_t q[$];

   thermo_actuator #(.MIN_ON(4), .MIN_OFF(3), .CNT_W(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .Hon      (Hon),
      .Con      (Con),
      .heat_out (heat_out),
      .cool_out (cool_out),
      .fault    (fault),
      .state    (state)
   );

   always #5 clk = ~clk;

   task automatic check_now(input string name, input logic [1:0] st,
                            input logic ho, input logic co, input logic f);
      checks++;
      if (state !== st || heat_out !== ho || cool_out !== co || fault !== f) begin
         errors++;
         $display("FAIL %s: got st=%0d heat=%b cool=%b fault=%b, want st=%0d heat=%b cool=%b fault=%b",
                  name, state, heat_out, cool_out, fault, st, ho, co, f);
      end
   endtask

   // Drive inputs mid-cycle; the expected outputs after the next rising edge
   // are queued and checked by the monitor at the following falling edge.
   task automatic step(input logic e, input logic h, input logic c,
                       input logic [1:0] st, input logic ho, input logic co,
                       input logic f, input string name);
      exp_t x;
      @(negedge clk);
      #2;
      en = e; Hon = h; Con = c;
      x.st = st; x.ho = ho; x.co = co; x.f = f; x.name = name;
      q.push_back(x);
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            x = q.pop_front();
            check_now(x.name, x.st, x.ho, x.co, x.f);
         end
      end
   end

   initial begin : stim
      int budget;
      rst_n = 1'b0; en = 1'b1; Hon = 1'b1; Con = 1'b0;

      // Reset held with heat demand present
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_now("reset_hold", 2'd0, 1'b0, 1'b0, 1'b0);
      end
      #2; Hon = 1'b0;
      rst_n = 1'b1;

      // Single-cycle heat demand: 4 heat cycles, 3 rest cycles
      step(1, 1, 0, 2'd1, 1, 0, 0, "s2_start");
      step(1, 0, 0, 2'd1, 1, 0, 0, "s2_heat1");
      step(1, 0, 0, 2'd1, 1, 0, 0, "s2_heat2");
      step(1, 0, 0, 2'd1, 1, 0, 0, "s2_heat3");
      step(1, 0, 0, 2'd3, 0, 0, 0, "s2_rest0");
      step(1, 0, 0, 2'd3, 0, 0, 0, "s2_rest1");
      step(1, 0, 0, 2'd3, 0, 0, 0, "s2_rest2");
      step(1, 0, 0, 2'd0, 0, 0, 0, "s2_idle");

      // Demand held 10 cycles, then Con ignored during rest
      for (int i = 0; i < 10; i++)
         step(1, 1, 0, 2'd1, 1, 0, 0, "s3_heat_long");
      step(1, 0, 0, 2'd3, 0, 0, 0, "s3_rest0");
      step(1, 0, 1, 2'd3, 0, 0, 0, "s3_rest_con1");
      step(1, 0, 1, 2'd3, 0, 0, 0, "s3_rest_con2");
      step(1, 0, 0, 2'd0, 0, 0, 0, "s3_idle");
      step(1, 0, 1, 2'd2, 0, 1, 0, "s3_cool_start");
      step(1, 0, 0, 2'd2, 0, 1, 0, "s3_cool1");
      step(1, 0, 0, 2'd2, 0, 1, 0, "s3_cool2");
      step(1, 0, 0, 2'd2, 0, 1, 0, "s3_cool3");
      step(1, 0, 0, 2'd3, 0, 0, 0, "s3_rest_a");
      step(1, 0, 0, 2'd3, 0, 0, 0, "s3_rest_b");
      step(1, 0, 0, 2'd3, 0, 0, 0, "s3_rest_c");
      step(1, 0, 0, 2'd0, 0, 0, 0, "s3_idle2");

      // Contradictory demand: fault only, stays idle
      step(1, 1, 1, 2'd0, 0, 0, 1, "s4_fault1");
      step(1, 1, 1, 2'd0, 0, 0, 1, "s4_fault2");
      step(1, 0, 0, 2'd0, 0, 0, 0, "s4_clear");

      // Enable dropped at cnt=1 of a cool run; en/Con ignored in rest
      step(1, 0, 1, 2'd2, 0, 1, 0, "s5_cool_start");
      step(1, 0, 0, 2'd2, 0, 1, 0, "s5_cool1");
      step(0, 0, 0, 2'd3, 0, 0, 0, "s5_en_drop");
      step(1, 0, 1, 2'd3, 0, 0, 0, "s5_rest_ign1");
      step(1, 0, 1, 2'd3, 0, 0, 0, "s5_rest_ign2");
      step(1, 0, 0, 2'd0, 0, 0, 0, "s5_idle");

      // Async reset in the middle of a heat run
      step(1, 1, 0, 2'd1, 1, 0, 0, "s6_start");
      step(1, 0, 0, 2'd1, 1, 0, 0, "s6_heat1");
      budget = 0;
      while (q.size() > 0 && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      @(posedge clk);
      #2;
      check_now("s6_pre_reset", 2'd1, 1'b1, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      check_now("s6_async_drop", 2'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      step(1, 0, 0, 2'd0, 0, 0, 0, "s6_after1");
      step(1, 0, 0, 2'd0, 0, 0, 0, "s6_after2");

      budget = 0;
      while (q.size() > 0 && budget < 50) begin
         @(negedge clk);
         budget++;
      end
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, want 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/thermo_actuator.md
# thermo_actuator

Sequential actuator controller that consumes the `Hon`/`Con` demand flags produced by the thermostat comparator and drives the physical heater and cooler enables. It enforces a minimum run time and a post-run rest (anti-short-cycle) interval, keeps heater and cooler mutually exclusive, and flags contradictory demands. It sits between the thermostat comparator and the plant output pins.

## Interface
Parameters:
- `MIN_ON`, default 16: minimum cycles an actuator stays on once started; must be ≥ 1.
- `MIN_OFF`, default 16: rest cycles with both actuators off after any run; must be ≥ 1.
- `CNT_W`, default 8: dwell counter width; must satisfy 2^CNT_W > max(MIN_ON, MIN_OFF).

Ports:
- Clock and reset (already decided): one clock; reset is asynchronous and active-low.
- `clk` input 1: single clock for the whole block.
- `rst_n` input 1: asynchronous reset, active low.
- `en` input 1: master enable; low means do not start, and stop any active run.
- `Hon` input 1: heat demand from the thermostat comparator.
- `Con` input 1: cool demand from the thermostat comparator.
- `heat_out` output 1: heater enable, registered.
- `cool_out` output 1: cooler enable, registered.
- `fault` output 1: registered `Hon & Con`, meaning contradictory demand.
- `state` output 2: current FSM state, with encoding IDLE=0, HEAT=1, COOL=2, REST=3.

## Operation
- Effective demands: `h = Hon & ~Con`, `c = Con & ~Hon`. When both are high, neither demand counts.
- `fault` is set on each edge to `Hon & Con` as sampled. It is not sticky.
- Dwell counter `cnt`, CNT_W bits: cleared on every state change, otherwise increments each cycle, saturating at all-ones.
- IDLE:
  - `en & h` → HEAT.
  - else `en & c` → COOL.
  - else stay in IDLE.
- HEAT:
  - `~en` → REST immediately. `MIN_ON` is not honoured.
  - else if `cnt >= MIN_ON-1` and `~h` → REST.
  - else stay in HEAT.
  - A `c` demand never switches HEAT directly to COOL.
- COOL: symmetric to HEAT, using `c`.
- REST:
  - `cnt == MIN_OFF-1` → IDLE.
  - `Hon`, `Con` and `en` are all ignored during REST.
- Outputs: `heat_out = (state==HEAT)` and `cool_out = (state==COOL)`, both taken from registered state. They are never high simultaneously.
- Reset values: state IDLE, `cnt` 0, `heat_out` 0, `cool_out` 0, `fault` 0.

## Timing
- Start latency: a demand sampled at edge k in IDLE raises the output after edge k, visible from cycle k+1.
- Run length: output is high for max(`MIN_ON`, number of consecutive cycles the demand is sampled high) cycles.
- Off time: minimum `MIN_OFF` cycles in REST, plus at least one IDLE cycle. So the minimum gap between runs is `MIN_OFF`+1 cycles.
- `en` deassert during a run: output drops after the edge that samples `en`=0.
- Async reset mid-run: `heat_out` and `cool_out` drop immediately, without waiting for a clock edge. After release, the block starts in IDLE with no pending demand remembered.
- Demand toggling within `MIN_ON` has no effect on the output.

## Structure
- Shared package `thermo_pkg` holds:
  - the `thermo_state_t` typedef, 2-bit, with the IDLE/HEAT/COOL/REST encoding above;
  - the default `MIN_ON`/`MIN_OFF` constants, shared with the thermostat top level.
- Sub-module `dwell_timer`: a CNT_W-bit saturating counter with synchronous clear and async active-low reset. It is instantiated once.

## Test plan
All scenarios use `MIN_ON`=4 and `MIN_OFF`=3.
1. Assert `rst_n`=0 with `Hon`=1 → `heat_out`=0, `cool_out`=0, `fault`=0, `state`=0 throughout reset.
2. `Hon` high for 1 cycle with `en`=1 → `heat_out` high for exactly 4 cycles starting the cycle after sampling. Then `state`=3 for 3 cycles, then 0.
3. `Hon` held for 10 cycles → `heat_out` high for exactly 10 cycles. `Con` pulsed during REST → ignored; `cool_out` rises 1 cycle after the first IDLE sample of `Con`.
4. `Hon`=`Con`=1 in IDLE for 2 cycles → `fault` high for 2 cycles, one cycle late. No actuator turns on; the block stays in IDLE.
5. `en` dropped at `cnt`=1 of a COOL run → `cool_out` low the next cycle, `state`=3, REST lasts 3 cycles.
6. `rst_n` pulsed low asynchronously mid-HEAT → `heat_out` falls before the next clock edge. After release, `state`=0.
